// File: rtl/raster_csr_unit_pkg.sv
// Shared types and constants for the raster/texture CSR block: field widths,
// CSR window offsets, the commit FSM state type and the active CSR struct.
package raster_csr_unit_pkg;

  // Texture field widths carried by the CSR struct
  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_MIPOFF_BITS = 20;
  localparam int TEX_LOD_MAX     = 7;
  localparam int NUM_LODS        = TEX_LOD_MAX + 1;
  localparam int MIP_IDX_BITS    = $clog2(NUM_LODS);

  // Default CSR bus geometry
  localparam int CSR_ADDR_BITS = 8;
  localparam int CSR_DATA_BITS = 32;

  // Offsets inside the raster CSR window
  localparam logic [7:0] RASTER_CSR_BADDR   = 8'h00;
  localparam logic [7:0] RASTER_CSR_FORMAT  = 8'h01;
  localparam logic [7:0] RASTER_CSR_FILTER  = 8'h02;
  localparam logic [7:0] RASTER_CSR_WRAP0   = 8'h03;
  localparam logic [7:0] RASTER_CSR_WRAP1   = 8'h04;
  localparam logic [7:0] RASTER_CSR_LOGDIM0 = 8'h05;
  localparam logic [7:0] RASTER_CSR_LOGDIM1 = 8'h06;
  localparam logic [7:0] RASTER_CSR_COMMIT  = 8'h07;
  localparam logic [7:0] RASTER_CSR_MIPOFF  = 8'h10;

  // Field one-hot positions produced by the decoder
  localparam int FLD_BADDR   = 0;
  localparam int FLD_FORMAT  = 1;
  localparam int FLD_FILTER  = 2;
  localparam int FLD_WRAP0   = 3;
  localparam int FLD_WRAP1   = 4;
  localparam int FLD_LOGDIM0 = 5;
  localparam int FLD_LOGDIM1 = 6;
  localparam int FLD_MIPOFF  = 7;
  localparam int NUM_SCALAR  = 7;
  localparam int NUM_FIELDS  = 8;

  // Offset of each scalar field, indexed by its one-hot position
  localparam logic [NUM_SCALAR-1:0][7:0] RASTER_CSR_FIELD_OFFSET = {
    RASTER_CSR_LOGDIM1, RASTER_CSR_LOGDIM0, RASTER_CSR_WRAP1, RASTER_CSR_WRAP0,
    RASTER_CSR_FILTER, RASTER_CSR_FORMAT, RASTER_CSR_BADDR
  };

  typedef enum logic {
    RASTER_CSR_IDLE = 1'b0,
    RASTER_CSR_PEND = 1'b1
  } raster_csr_state_t;

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                    baddr;
    logic [TEX_FORMAT_BITS-1:0]                  format;
    logic [TEX_FILTER_BITS-1:0]                  filter;
    logic [1:0][TEX_WRAP_BITS-1:0]               wrap;
    logic [1:0][TEX_LOD_BITS-1:0]                logdim;
    logic [NUM_LODS-1:0][TEX_MIPOFF_BITS-1:0]    mipoff;
  } raster_csrs_t;

endpackage

// File: rtl/raster_csr_unit_if.sv
// CSR access bus between the core (master) and the raster CSR unit (slave).
interface raster_csr_unit_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) ();

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd_valid;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/raster_csr_unit_decode.sv
// Combinational CSR offset decoder; one instance serves the write port and
// another the read port so both agree on the address map.
module raster_csr_unit_decode
  import raster_csr_unit_pkg::*;
#(
  parameter int ADDR_BITS = CSR_ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0]    addr,
  output logic [NUM_FIELDS-1:0]   field,
  output logic [MIP_IDX_BITS-1:0] mip_idx,
  output logic                    is_commit,
  output logic                    is_err
);

  // Distance from the start of the mipoff block; the extra MSB flags underflow
  logic [ADDR_BITS:0] mip_rel;

  assign mip_rel = {1'b0, addr} - (ADDR_BITS + 1)'(RASTER_CSR_MIPOFF);

  generate
    for (genvar gi = 0; gi < NUM_SCALAR; gi++) begin : g_scalar
      assign field[gi] = (addr == ADDR_BITS'(RASTER_CSR_FIELD_OFFSET[gi]));
    end
  endgenerate

  assign field[FLD_MIPOFF] = !mip_rel[ADDR_BITS] &&
                             (mip_rel < (ADDR_BITS + 1)'(NUM_LODS));
  assign mip_idx   = mip_rel[MIP_IDX_BITS-1:0];
  assign is_commit = (addr == ADDR_BITS'(RASTER_CSR_COMMIT));
  assign is_err    = !(|field) && !is_commit;

endmodule

// File: rtl/raster_csr_unit.sv
// Raster/texture CSR producer: builds a shadow CSR set from core writes and
// transfers it atomically to the active set on COMMIT, deferring the transfer
// while the datapath holds the active set.
module raster_csr_unit
  import raster_csr_unit_pkg::*;
#(
  parameter int ADDR_BITS = CSR_ADDR_BITS,
  parameter int DATA_BITS = CSR_DATA_BITS
) (
  input  logic             clk,
  input  logic             reset,
  raster_csr_unit_if.slave bus,
  input  logic             csr_in_use,
  output raster_csrs_t     csrs,
  output logic             csr_update,
  output logic             csr_err
);

  raster_csr_state_t    state_reg;
  logic                 wr_ready_reg;
  raster_csrs_t         shadow_reg;
  raster_csrs_t         active_reg;
  logic                 csr_update_reg;
  logic                 csr_err_reg;
  logic                 rsp_valid_reg;
  logic [DATA_BITS-1:0] rsp_data_reg;
  logic [DATA_BITS-1:0] rd_value;

  logic [NUM_FIELDS-1:0]   w_field;
  logic [MIP_IDX_BITS-1:0] w_mip_idx;
  logic                    w_is_commit;
  logic                    w_is_err;
  logic [NUM_FIELDS-1:0]   r_field;
  logic [MIP_IDX_BITS-1:0] r_mip_idx;
  logic                    r_is_commit;
  logic                    r_is_err;
  logic                    wr_acc;

  raster_csr_unit_decode #(.ADDR_BITS(ADDR_BITS)) u_wr_decode (
    .addr      (bus.wr_addr),
    .field     (w_field),
    .mip_idx   (w_mip_idx),
    .is_commit (w_is_commit),
    .is_err    (w_is_err)
  );

  raster_csr_unit_decode #(.ADDR_BITS(ADDR_BITS)) u_rd_decode (
    .addr      (bus.rd_addr),
    .field     (r_field),
    .mip_idx   (r_mip_idx),
    .is_commit (r_is_commit),
    .is_err    (r_is_err)
  );

  // wr_ready is low only in PEND, so an accepted write always happens in IDLE
  assign wr_acc = bus.wr_valid && wr_ready_reg;

  // Commit FSM: owns the active set, the update pulse and write backpressure
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= RASTER_CSR_IDLE;
      wr_ready_reg   <= 1'b1;
      active_reg     <= '0;
      csr_update_reg <= 1'b0;
    end else begin
      csr_update_reg <= 1'b0;
      case (state_reg)
        RASTER_CSR_IDLE: begin
          if (wr_acc && w_is_commit) begin
            if (!csr_in_use) begin
              active_reg     <= shadow_reg;
              csr_update_reg <= 1'b1;
            end else begin
              state_reg    <= RASTER_CSR_PEND;
              wr_ready_reg <= 1'b0;
            end
          end
        end
        RASTER_CSR_PEND: begin
          if (!csr_in_use) begin
            active_reg     <= shadow_reg;
            csr_update_reg <= 1'b1;
            state_reg      <= RASTER_CSR_IDLE;
            wr_ready_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg    <= RASTER_CSR_IDLE;
          wr_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Shadow field updates; each field keeps only the low bits of the write data
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_reg <= '0;
    end else if (wr_acc) begin
      if (w_field[FLD_BADDR])   shadow_reg.baddr     <= bus.wr_data[TEX_ADDR_BITS-1:0];
      if (w_field[FLD_FORMAT])  shadow_reg.format    <= bus.wr_data[TEX_FORMAT_BITS-1:0];
      if (w_field[FLD_FILTER])  shadow_reg.filter    <= bus.wr_data[TEX_FILTER_BITS-1:0];
      if (w_field[FLD_WRAP0])   shadow_reg.wrap[0]   <= bus.wr_data[TEX_WRAP_BITS-1:0];
      if (w_field[FLD_WRAP1])   shadow_reg.wrap[1]   <= bus.wr_data[TEX_WRAP_BITS-1:0];
      if (w_field[FLD_LOGDIM0]) shadow_reg.logdim[0] <= bus.wr_data[TEX_LOD_BITS-1:0];
      if (w_field[FLD_LOGDIM1]) shadow_reg.logdim[1] <= bus.wr_data[TEX_LOD_BITS-1:0];
      if (w_field[FLD_MIPOFF])  shadow_reg.mipoff[w_mip_idx] <= bus.wr_data[TEX_MIPOFF_BITS-1:0];
    end
  end

  // Read mux over the current (pre-write) shadow, zero-extended to the bus width
  always_comb begin
    rd_value = '0;
    if (r_field[FLD_BADDR])   rd_value = DATA_BITS'(shadow_reg.baddr);
    if (r_field[FLD_FORMAT])  rd_value = DATA_BITS'(shadow_reg.format);
    if (r_field[FLD_FILTER])  rd_value = DATA_BITS'(shadow_reg.filter);
    if (r_field[FLD_WRAP0])   rd_value = DATA_BITS'(shadow_reg.wrap[0]);
    if (r_field[FLD_WRAP1])   rd_value = DATA_BITS'(shadow_reg.wrap[1]);
    if (r_field[FLD_LOGDIM0]) rd_value = DATA_BITS'(shadow_reg.logdim[0]);
    if (r_field[FLD_LOGDIM1]) rd_value = DATA_BITS'(shadow_reg.logdim[1]);
    if (r_field[FLD_MIPOFF])  rd_value = DATA_BITS'(shadow_reg.mipoff[r_mip_idx]);
    if (r_is_commit)          rd_value = DATA_BITS'(state_reg == RASTER_CSR_PEND);
  end

  // Registered read response and unmapped-access error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      csr_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= bus.rd_valid;
      rsp_data_reg  <= bus.rd_valid ? rd_value : '0;
      csr_err_reg   <= (wr_acc && w_is_err) || (bus.rd_valid && r_is_err);
    end
  end

  assign bus.wr_ready  = wr_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign csrs          = active_reg;
  assign csr_update    = csr_update_reg;
  assign csr_err       = csr_err_reg;

endmodule

// File: tb/tb_raster_csr_unit.sv
// Directed bench for raster_csr_unit: an offset-indexed register model
// predicts every output each cycle; literal checks pin key scenarios.
module tb_raster_csr_unit;
  import raster_csr_unit_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         csr_in_use = 1'b0;
  raster_csrs_t csrs;
  logic         csr_update;
  logic         csr_err;

  raster_csr_unit_if #(.ADDR_BITS(8), .DATA_BITS(32)) bus ();

  raster_csr_unit #(.ADDR_BITS(8), .DATA_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .csr_in_use (csr_in_use),
    .csrs       (csrs),
    .csr_update (csr_update),
    .csr_err    (csr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: one 32-bit word per CSR offset
  bit [31:0]    m_sh [256];
  bit [31:0]    m_act [256];
  bit           m_pend = 1'b0;
  bit           m_valid = 1'b0;
  bit           e_update, e_err, e_rsp_valid, e_ready;
  bit [31:0]    e_rsp_data;

  function automatic int fwidth(int a);
    case (a)
      0:       return TEX_ADDR_BITS;
      1:       return TEX_FORMAT_BITS;
      2:       return TEX_FILTER_BITS;
      3, 4:    return TEX_WRAP_BITS;
      5, 6:    return TEX_LOD_BITS;
      default: return (a >= 16 && a < 16 + NUM_LODS) ? TEX_MIPOFF_BITS : 0;
    endcase
  endfunction

  function automatic bit [31:0] fmask(int w);
    bit [63:0] one = 64'd1;
    return 32'((one << w) - 64'd1);
  endfunction

  function automatic raster_csrs_t model_csrs();
    raster_csrs_t r;
    r.baddr     = m_act[0];
    r.format    = m_act[1][TEX_FORMAT_BITS-1:0];
    r.filter    = m_act[2][TEX_FILTER_BITS-1:0];
    r.wrap[0]   = m_act[3][TEX_WRAP_BITS-1:0];
    r.wrap[1]   = m_act[4][TEX_WRAP_BITS-1:0];
    r.logdim[0] = m_act[5][TEX_LOD_BITS-1:0];
    r.logdim[1] = m_act[6][TEX_LOD_BITS-1:0];
    for (int i = 0; i < NUM_LODS; i++) r.mipoff[i] = m_act[16+i][TEX_MIPOFF_BITS-1:0];
    return r;
  endfunction

  // Model update on each clock edge from the inputs the DUT sees
  always @(posedge clk) begin
    int ra, wa;
    ra = int'(bus.rd_addr);
    wa = int'(bus.wr_addr);
    m_valid = 1'b1;
    e_update = 1'b0; e_err = 1'b0; e_rsp_valid = 1'b0; e_rsp_data = 32'd0;
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin m_sh[i] = 32'd0; m_act[i] = 32'd0; end
      m_pend = 1'b0;
    end else begin
      if (bus.rd_valid) begin
        e_rsp_valid = 1'b1;
        if (ra == 7) e_rsp_data = {31'd0, m_pend};
        else if (fwidth(ra) > 0) e_rsp_data = m_sh[ra];
        else e_err = 1'b1;
      end
      if (bus.wr_valid && !m_pend) begin
        if (wa == 7) begin
          if (!csr_in_use) begin m_act = m_sh; e_update = 1'b1; end
          else m_pend = 1'b1;
        end else if (fwidth(wa) > 0) begin
          m_sh[wa] = bus.wr_data & fmask(fwidth(wa));
        end else begin
          e_err = 1'b1;
        end
      end else if (m_pend && !csr_in_use) begin
        m_act = m_sh; e_update = 1'b1; m_pend = 1'b0;
      end
    end
    e_ready = !m_pend;
  end

  task automatic cmp(string name, logic [255:0] got, logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("csrs", csrs, model_csrs());
      cmp("csr_update", csr_update, e_update);
      cmp("csr_err", csr_err, e_err);
      cmp("rsp_valid", bus.rsp_valid, e_rsp_valid);
      cmp("rsp_data", bus.rsp_data, e_rsp_data);
      cmp("wr_ready", bus.wr_ready, e_ready);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    cyc();
    bus.wr_valid = 1'b0;
    $display("write addr=%02h data=%08h err=%0b", a, d, csr_err);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    cyc();
    bus.rd_valid = 1'b0;
    d = bus.rsp_data;
    $display("read  addr=%02h data=%08h err=%0b", a, d, csr_err);
  endtask

  initial begin
    logic [31:0] d;
    raster_csrs_t zero_csrs;
    zero_csrs = '0;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h00; bus.wr_data = 32'hFFFF_FFFF;
    bus.rd_valid = 1'b0; bus.rd_addr = 8'h00;

    // 1: reset held with a write pending on the bus
    repeat (3) cyc();
    cmp("t1_csrs", csrs, zero_csrs);
    cmp("t1_rsp_valid", bus.rsp_valid, 1'b0);
    cmp("t1_update", csr_update, 1'b0);
    reset = 1'b1; bus.wr_valid = 1'b0;
    cyc();
    cmp("t1_wr_ready", bus.wr_ready, 1'b1);

    // 2: build shadow then commit with datapath idle
    wr(8'h00, 32'hDEAD_BEEF);
    wr(8'h01, 32'h0000_00FB);
    wr(8'h10, 32'h0000_0040);
    cmp("t2_csrs_before", csrs, zero_csrs);
    wr(8'h07, 32'h0);
    cmp("t2_update", csr_update, 1'b1);
    cmp("t2_baddr", csrs.baddr, 32'hDEAD_BEEF);
    cmp("t2_format", csrs.format, 3'd3);
    cmp("t2_mipoff0", csrs.mipoff[0], 20'h40);
    cyc();
    cmp("t2_update_end", csr_update, 1'b0);

    // 3: commit deferred while the active set is in use
    wr(8'h02, 32'h2);
    csr_in_use = 1'b1;
    wr(8'h07, 32'h5A);
    cmp("t3_wr_ready", bus.wr_ready, 1'b0);
    rd(8'h07, d);
    cmp("t3_pending", d, 32'd1);
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h02; bus.wr_data = 32'h1;
    cyc();
    bus.wr_valid = 1'b0;
    repeat (2) cyc();
    cmp("t3_filter_held", csrs.filter, 2'd0);
    csr_in_use = 1'b0;
    cyc();
    cmp("t3_update", csr_update, 1'b1);
    cmp("t3_filter", csrs.filter, 2'd2);
    cmp("t3_wr_ready_back", bus.wr_ready, 1'b1);
    rd(8'h07, d);
    cmp("t3_pending_clr", d, 32'd0);

    // 4: read and write of the same offset in one cycle
    wr(8'h05, 32'h2);
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h05;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = 32'h7;
    cyc();
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    cmp("t4_old", bus.rsp_data, 32'd2);
    rd(8'h05, d);
    cmp("t4_new", d, 32'd7);
    rd(8'h17, d);
    cmp("t4_last_mip", d, 32'd0);

    // 5: unmapped write and read
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h3F;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h3F; bus.wr_data = 32'h1234_5678;
    cyc();
    bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
    cmp("t5_err", csr_err, 1'b1);
    cmp("t5_rsp", bus.rsp_data, 32'd0);
    cyc();
    cmp("t5_err_end", csr_err, 1'b0);
    wr(8'h18, 32'h9);
    cmp("t5_err_mip_oob", csr_err, 1'b1);

    // 6: reset while a commit is pending
    wr(8'h06, 32'h5);
    csr_in_use = 1'b1;
    wr(8'h07, 32'h0);
    cmp("t6_pend", bus.wr_ready, 1'b0);
    reset = 1'b0;
    cyc();
    reset = 1'b1; csr_in_use = 1'b0;
    cmp("t6_csrs", csrs, zero_csrs);
    cmp("t6_wr_ready", bus.wr_ready, 1'b1);
    repeat (3) cyc();
    cmp("t6_no_update", csr_update, 1'b0);
    cmp("t6_csrs_still", csrs, zero_csrs);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
